axi_fanin_arb_req: RTL

AXI_FANIN_ARB_REQ -- requirements
Module: axi_fanin_arb_req

---
 rtl/axi_fanin_pkg.sv | 19 +
 rtl/axi_rr_prio_search.sv | 35 +++
 rtl/axi_fanin_arb_req.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/axi_fanin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_fanin_pkg
// Description : Shared constants and the pointer-width helper for the
//               request fan-in arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_fanin_pkg;

  // Largest number of request inputs the arbiter is built for
  localparam int MAX_N_INIT = 16;

  // Width of an index into n inputs (never narrower than one bit)
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rr_prio_search.sv
`default_nettype none
// ============================================================================
// Module      : axi_rr_prio_search
// Description : Combinational circular priority search. Returns the first
//               set bit of req at or above ptr, wrapping past N-1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rr_prio_search #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);

  // Scan offsets from the far end back to zero so the closest hit wins
  always_comb begin
    int k;
    k     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      k = int'(ptr) + off;
      if (k >= N) k = k - N;
      if (req[k]) begin
        idx   = PW'(k);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_fanin_arb_req.sv
`default_nettype none
// ============================================================================
// Module      : axi_fanin_arb_req
// Description : N-input round-robin request arbiter with sticky hold on
//               back-pressure and an exclusive-lock override.
//               Optional build macro AXI_FANIN_OUT_REG_EN inserts a one-entry
//               output register slice between the arbiter and downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_fanin_arb_req
  import axi_fanin_pkg::*;
#(
  parameter int N_INIT    = 4,
  parameter int AUX_WIDTH = 32,
  parameter int ID_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_INIT-1:0]           data_req_i,
  input  logic [N_INIT*AUX_WIDTH-1:0] data_AUX_i,
  input  logic [N_INIT*ID_WIDTH-1:0]  data_ID_i,
  output logic [N_INIT-1:0]           data_gnt_o,
  output logic                        data_req_o,
  output logic [AUX_WIDTH-1:0]        data_AUX_o,
  output logic [ID_WIDTH-1:0]         data_ID_o,
  input  logic                        data_gnt_i,
  input  logic                        lock_EXCLUSIVE,
  input  logic [$clog2(N_INIT)-1:0]   SEL_EXCLUSIVE
);

  localparam int            PW     = ptr_width(N_INIT);
  localparam logic [PW-1:0] C_LAST = PW'(N_INIT - 1);

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 hold_q, hold_d;
  logic [PW-1:0]        hold_idx_q, hold_idx_d;

  logic [PW-1:0]        w_srch_idx;
  logic                 w_srch_valid;
  logic [PW-1:0]        w_sel;
  logic                 w_sel_ok;
  logic                 w_in_req;
  logic                 w_dn_ready;
  logic                 w_in_hs;
  logic                 w_lock_ok;
  logic                 w_hold_ok;
  logic [N_INIT-1:0]    w_gnt;
  logic [AUX_WIDTH-1:0] w_aux [N_INIT];
  logic [ID_WIDTH-1:0]  w_id  [N_INIT];

  // Unpack the flat payload/ID buses into per-input arrays
  for (genvar k = 0; k < N_INIT; k++) begin : g_unpack
    assign w_aux[k] = data_AUX_i[k*AUX_WIDTH +: AUX_WIDTH];
    assign w_id[k]  = data_ID_i[k*ID_WIDTH +: ID_WIDTH];
  end

  axi_rr_prio_search #(
    .N  (N_INIT),
    .PW (PW)
  ) u_search (
    .req   (data_req_i),
    .ptr   (rr_ptr_q),
    .idx   (w_srch_idx),
    .valid (w_srch_valid)
  );

  // Selection: lock overrides hold, hold overrides the round-robin search
  always_comb begin
    w_lock_ok = (int'(SEL_EXCLUSIVE) < N_INIT);
    w_hold_ok = hold_q & data_req_i[hold_idx_q];
    w_sel     = '0;
    w_sel_ok  = 1'b1;
    w_in_req  = 1'b0;
    if (lock_EXCLUSIVE) begin
      w_sel_ok = w_lock_ok;
      w_sel    = w_lock_ok ? PW'(SEL_EXCLUSIVE) : '0;
      w_in_req = w_lock_ok & data_req_i[w_sel];
    end else begin
      w_in_req = |data_req_i;
      if (w_hold_ok)         w_sel = hold_idx_q;
      else if (w_srch_valid) w_sel = w_srch_idx;
    end
  end

  // One-hot grant back to the selected input, driven by the local ready
  always_comb begin
    w_gnt = '0;
    if (w_sel_ok) w_gnt[w_sel] = w_dn_ready;
  end

  assign data_gnt_o = w_gnt;
  assign w_in_hs    = w_in_req & w_dn_ready;

  // Pointer advance on handshake; hold the winner while it is back-pressured
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    hold_d     = 1'b0;
    hold_idx_d = hold_idx_q;
    if (!lock_EXCLUSIVE) begin
      if (w_in_hs) begin
        rr_ptr_d = (w_sel == C_LAST) ? '0 : w_sel + 1'b1;
      end else if (w_in_req) begin
        hold_d     = 1'b1;
        hold_idx_d = w_sel;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

`ifdef AXI_FANIN_OUT_REG_EN
  logic                 full_q, full_d;
  logic [AUX_WIDTH-1:0] aux_q;
  logic [ID_WIDTH-1:0]  id_q;

  // The slice can take a new beat when empty or when it drains this cycle;
  // reset forces it not-ready so no grant escapes during reset
  assign w_dn_ready = rst_n & (~full_q | data_gnt_i);
  assign full_d     = w_in_hs | (full_q & ~data_gnt_i);

  // One-entry output register slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      aux_q  <= '0;
      id_q   <= '0;
    end else begin
      full_q <= full_d;
      if (w_in_hs) begin
        aux_q <= w_aux[w_sel];
        id_q  <= w_id[w_sel];
      end
    end
  end

  assign data_req_o = full_q;
  assign data_AUX_o = aux_q;
  assign data_ID_o  = id_q;
`else
  assign w_dn_ready = data_gnt_i;
  assign data_req_o = w_in_req;
  assign data_AUX_o = w_aux[w_sel];
  assign data_ID_o  = w_id[w_sel];
`endif

endmodule
`default_nettype wire
